// File: rtl/audio_volume_ctrl.sv
// ---------------------------------------------------------------------------
// audio_volume_ctrl
//   Volume controller between the volume buttons/mute switch and the volume
//   port of note_gen. It keeps a user level, steps it with a geometric or a
//   linear law, auto-repeats while a button is held, and fades the applied
//   volume one unit per tick toward the target (0 when muted, else level).
//
// Ports
//   clk       in   1      system clock
//   rst       in   1      asynchronous, active-high reset
//   vol_up    in   1      volume-up button level (debounced, synchronous)
//   vol_down  in   1      volume-down button level (debounced, synchronous)
//   mute      in   1      mute switch level
//   level     out  VOL_W  stored user volume level (unaffected by mute)
//   vol_out   out  VOL_W  applied volume, drives note_gen
//   at_max    out  1      level is all ones
//   at_min    out  1      level is 1
//   fading    out  1      vol_out differs from the current target
//   state_dbg out  2      button FSM state (0 IDLE, 1 HOLD, 2 REPEAT)
//
// Button inputs are plain levels, not a valid/ready handshake: a request is
// "exactly one button high" and is sampled every clk cycle.
// ---------------------------------------------------------------------------
module audio_volume_ctrl #(
    parameter int VOL_W        = 5,
    parameter int VOL_INIT     = 7,
    parameter int LIN_MODE     = 0,
    parameter int STEP         = 1,
    parameter int TICK_DIV     = 20,
    parameter int HOLD_TICKS   = 16,
    parameter int REPEAT_TICKS = 4,
    parameter int FADE_EN      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vol_up,
    input  logic             vol_down,
    input  logic             mute,
    output logic [VOL_W-1:0] level,
    output logic [VOL_W-1:0] vol_out,
    output logic             at_max,
    output logic             at_min,
    output logic             fading,
    output logic [1:0]       state_dbg
);

    localparam int MAX_T = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [VOL_W-1:0] INIT_V      = VOL_W'(VOL_INIT);
    localparam logic [VOL_W:0]   ONES_W      = {1'b0, {VOL_W{1'b1}}};
    localparam logic [VOL_W:0]   STEP_W      = (VOL_W+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    btn_state_t         state;
    logic               dir_up;
    logic [CNT_W-1:0]   tick_count;
    logic [TICK_DIV-1:0] tick_cnt;
    logic               tick;
    logic               req;
    logic               abort;
    logic [VOL_W-1:0]   target;

    // One saturating step of the level; math is one bit wider so an
    // overflow or underflow is visible before clamping into 1..all-ones.
    function automatic logic [VOL_W-1:0] step_vol(input logic [VOL_W-1:0] v,
                                                  input logic up);
        logic [VOL_W:0] w;
        w = '0;
        if (LIN_MODE == 0) begin
            if (up) begin
                w = {v, 1'b1};
                if (w > ONES_W) w = ONES_W;
            end else begin
                w = {2'b00, v[VOL_W-1:1]};
                if (w == '0) w = (VOL_W+1)'(1);
            end
        end else begin
            if (up) begin
                w = {1'b0, v} + STEP_W;
                if (w > ONES_W) w = ONES_W;
            end else if ({1'b0, v} > STEP_W) begin
                w = {1'b0, v} - STEP_W;
            end else begin
                w = (VOL_W+1)'(1);
            end
        end
        return w[VOL_W-1:0];
    endfunction

    // Free-running tick prescaler: tick fires when the counter is all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick   = &tick_cnt;
    assign req    = vol_up ^ vol_down;
    assign target = mute ? '0 : level;

    // Leave HOLD/REPEAT when the latched button is released, the opposite
    // one is pressed (this also covers both high), or mute is asserted.
    assign abort = mute || (dir_up ? (!vol_up || vol_down) : (!vol_down || vol_up));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            level      <= INIT_V;
            dir_up     <= 1'b0;
            tick_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !mute) begin
                        level      <= step_vol(level, vol_up);
                        dir_up     <= vol_up;
                        tick_count <= '0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (tick_count == HOLD_LAST) begin
                            level      <= step_vol(level, dir_up);
                            tick_count <= '0;
                            state      <= REPEAT;
                        end else begin
                            tick_count <= tick_count + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (tick_count == REPEAT_LAST) begin
                            level      <= step_vol(level, dir_up);
                            tick_count <= '0;
                        end else begin
                            tick_count <= tick_count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Applied volume: a one-unit-per-tick ramp always heads toward the
    // current target, so a target change mid-fade simply redirects it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vol_out <= INIT_V;
        end else if (FADE_EN != 0) begin
            if (tick) begin
                if (vol_out < target)      vol_out <= vol_out + 1'b1;
                else if (vol_out > target) vol_out <= vol_out - 1'b1;
            end
        end else begin
            vol_out <= target;
        end
    end

    assign at_max    = &level;
    assign at_min    = (level == VOL_W'(1));
    assign fading    = (vol_out != target);
    assign state_dbg = state;

endmodule

// File: tb/tb_audio_volume_ctrl.sv
module tb_audio_volume_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vol_up = 1'b0, vol_down = 1'b0, mute = 1'b0;
    logic [4:0] level, vol_out;
    logic       at_max, at_min, fading;
    logic [1:0] state_dbg;

    logic       lin_up = 1'b0, lin_down = 1'b0;
    logic [4:0] lin_level, lin_vol;
    logic       lin_max, lin_min, lin_fading;
    logic [1:0] lin_state;

    logic       l30_up = 1'b0;
    logic [4:0] l30_level, l30_vol;
    logic       l30_max, l30_min, l30_fading;
    logic [1:0] l30_state;

    int total = 0;
    int bad   = 0;
    int jumps = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    audio_volume_ctrl #(
        .VOL_W(5), .VOL_INIT(7), .LIN_MODE(0), .STEP(1), .TICK_DIV(4),
        .HOLD_TICKS(2), .REPEAT_TICKS(1), .FADE_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .vol_up(vol_up), .vol_down(vol_down), .mute(mute),
        .level(level), .vol_out(vol_out), .at_max(at_max), .at_min(at_min),
        .fading(fading), .state_dbg(state_dbg)
    );

    audio_volume_ctrl #(
        .VOL_W(5), .VOL_INIT(7), .LIN_MODE(1), .STEP(3), .TICK_DIV(4),
        .HOLD_TICKS(2), .REPEAT_TICKS(1), .FADE_EN(1)
    ) dut_lin (
        .clk(clk), .rst(rst), .vol_up(lin_up), .vol_down(lin_down), .mute(1'b0),
        .level(lin_level), .vol_out(lin_vol), .at_max(lin_max), .at_min(lin_min),
        .fading(lin_fading), .state_dbg(lin_state)
    );

    audio_volume_ctrl #(
        .VOL_W(5), .VOL_INIT(30), .LIN_MODE(1), .STEP(3), .TICK_DIV(4),
        .HOLD_TICKS(2), .REPEAT_TICKS(1), .FADE_EN(1)
    ) dut_l30 (
        .clk(clk), .rst(rst), .vol_up(l30_up), .vol_down(1'b0), .mute(1'b0),
        .level(l30_level), .vol_out(l30_vol), .at_max(l30_max), .at_min(l30_min),
        .fading(l30_fading), .state_dbg(l30_state)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vol_up = 1'b0; vol_down = 1'b0; mute = 1'b0;
        lin_up = 1'b0; lin_down = 1'b0; l30_up = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive a one-cycle press, release, then let the FSM settle back to IDLE.
    task automatic pulse(input logic u, input logic d, input logic m);
        @(negedge clk);
        vol_up = u; vol_down = d; mute = m;
        @(negedge clk);
        vol_up = 1'b0; vol_down = 1'b0; mute = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_lin(input logic u, input logic d, input logic u30);
        @(negedge clk);
        lin_up = u; lin_down = d; l30_up = u30;
        @(negedge clk);
        lin_up = 1'b0; lin_down = 1'b0; l30_up = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Wait (bounded) for vol_out to reach tgt; counts any step larger than 1.
    task automatic wait_vol(input logic [4:0] tgt, input int bound, output bit ok);
        logic [4:0] prev;
        int d;
        ok = 1'b0;
        prev = vol_out;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            d = int'(vol_out) - int'(prev);
            if (d > 1 || d < -1) jumps++;
            prev = vol_out;
            if (vol_out == tgt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       up;
        logic       down;
        logic       mute;
        logic [4:0] exp_level;
        logic       exp_max;
        logic       exp_min;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit ok;
        int errs;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'd15, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'd15, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'd3,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 5'd3,  1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd3,  1'b0, 1'b0};

        // Reset state
        do_reset();
        check("rst_level", level, 7);
        check("rst_vol_out", vol_out, 7);
        check("rst_at_max", at_max, 0);
        check("rst_at_min", at_min, 0);
        check("rst_fading", fading, 0);
        check("rst_state", state_dbg, 0);

        // Table: single presses, saturation at both ends, ignored presses
        foreach (vecs[i]) begin
            pulse(vecs[i].up, vecs[i].down, vecs[i].mute);
            check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            check($sformatf("vec%0d_at_max", i), at_max, vecs[i].exp_max);
            check($sformatf("vec%0d_at_min", i), at_min, vecs[i].exp_min);
            check($sformatf("vec%0d_state", i), state_dbg, 0);
        end

        // Single press: one-cycle latency, then a 1-per-tick ramp 7 -> 15
        do_reset();
        @(negedge clk);
        vol_up = 1'b1;
        @(negedge clk);
        vol_up = 1'b0;
        check("press_latency_level", level, 15);
        check("press_fading_start", fading, 1);
        jumps = 0;
        wait_vol(5'd15, 200, ok);
        check("ramp_up_reached", ok, 1);
        check("ramp_up_fading_end", fading, 0);
        check("ramp_up_jumps", jumps, 0);

        // Press and hold: 15 at once, 31 after two ticks, then saturates
        do_reset();
        @(negedge clk);
        vol_up = 1'b1;
        @(negedge clk);
        check("hold_first_step", level, 15);
        repeat (16) @(negedge clk);
        check("hold_before_repeat", level, 15);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (level == 5'd31) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("hold_reaches_31", ok, 1);
        repeat (50) @(negedge clk);
        check("hold_no_wrap", level, 31);
        check("hold_at_max", at_max, 1);
        check("hold_state_repeat", state_dbg, 2);
        vol_up = 1'b0;

        // Mute: fade to 0 with level frozen, then fade back on unmute
        jumps = 0;
        wait_vol(5'd31, 600, ok);
        check("pre_mute_vol_31", ok, 1);
        @(negedge clk);
        mute = 1'b1;
        @(negedge clk);
        vol_down = 1'b1;
        @(negedge clk);
        vol_down = 1'b0;
        @(negedge clk);
        check("mute_press_ignored", level, 31);
        check("mute_state_idle", state_dbg, 0);
        check("mute_fading", fading, 1);
        wait_vol(5'd0, 600, ok);
        check("mute_fade_to_0", ok, 1);
        check("mute_fading_done", fading, 0);
        check("mute_level_kept", level, 31);
        mute = 1'b0;
        wait_vol(5'd31, 600, ok);
        check("unmute_fade_to_31", ok, 1);
        check("unmute_fading_done", fading, 0);
        check("mute_cycle_jumps", jumps, 0);

        // Both buttons held: no step, FSM stays IDLE
        @(negedge clk);
        vol_up = 1'b1; vol_down = 1'b1;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (level != 5'd31 || state_dbg != 2'd0) errs++;
        end
        vol_up = 1'b0; vol_down = 1'b0;
        check("both_buttons_errs", errs, 0);

        // Linear law, STEP=3
        do_reset();
        pulse_lin(1'b0, 1'b1, 1'b1);
        check("lin_down1", lin_level, 4);
        check("l30_up_sat", l30_level, 31);
        check("l30_at_max", l30_max, 1);
        pulse_lin(1'b0, 1'b1, 1'b0);
        check("lin_down2", lin_level, 1);
        check("lin_at_min", lin_min, 1);
        pulse_lin(1'b0, 1'b1, 1'b0);
        check("lin_down3", lin_level, 1);
        check("lin_at_min_sat", lin_min, 1);

        // Reset mid-fade and mid-hold
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("pre_abort_level", level, 31);
        wait_vol(5'd20, 400, ok);
        check("pre_abort_vol_20", ok, 1);
        vol_up = 1'b1;
        @(negedge clk);
        check("pre_abort_hold", state_dbg, 1);
        rst = 1'b1;
        #1;
        check("abort_level", level, 7);
        check("abort_vol_out", vol_out, 7);
        check("abort_fading", fading, 0);
        check("abort_state", state_dbg, 0);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (level != 5'd7 || vol_out != 5'd7 || fading || state_dbg != 2'd0) errs++;
        end
        check("rst_held_errs", errs, 0);
        vol_up = 1'b0;
        rst = 1'b0;

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
